// File: rtl/fixed_arg_subparser.sv
// -----------------------------------------------------------------------------
// fixed_arg_subparser
//
// Parses one command argument of the form  <title>[+|-]digits[.digits]<term>
// from a character source into a signed fixed-point number scaled by
// 10^FRAC_DIGITS. Characters are fetched one at a time via a request/deliver
// handshake; the terminator (space, CR, LF or source exhausted) is consumed.
// Magnitudes beyond the signed NUM_BITS range saturate and raise arg_too_big.
//
// Optional feature: define ARG_SUBPARSER_ROUND_EN to round the result up
// when the first discarded fraction digit is 5..9 (default: truncate).
//
// Ports
//   clk          clock, all state changes on its rising edge
//   reset        asynchronous, active-low reset
//   clk_en       advance enable; the block is frozen while low
//   trigger      start one parse (honoured only while rdy)
//   arg_title    expected title letter (ASCII)
//   char_in      source character, valid while rd_done=1
//   rd_rdy       source can accept a character request
//   rd_done      source is delivering char_in
//   is_empty     source has no more characters
//   rd_trigger   one-cycle character request to the source
//   rdy          idle, ready for trigger
//   done         one-cycle completion pulse
//   success      argument was syntactically valid
//   arg_too_big  magnitude saturated somewhere during the parse
//   has_frac     a '.' was parsed
//   num          signed fixed-point result (value * 10^FRAC_DIGITS)
// -----------------------------------------------------------------------------
module fixed_arg_subparser #(
    parameter int NUM_BITS    = 16,
    parameter int FRAC_DIGITS = 2,
    parameter int ACC_BITS    = NUM_BITS + 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                trigger,
    input  logic [7:0]          arg_title,
    input  logic [7:0]          char_in,
    input  logic                rd_rdy,
    input  logic                rd_done,
    input  logic                is_empty,
    output logic                rd_trigger,
    output logic                rdy,
    output logic                done,
    output logic                success,
    output logic                arg_too_big,
    output logic                has_frac,
    output logic [NUM_BITS-1:0] num
);

    typedef enum logic [3:0] {
        IDLE, FETCH, WAIT_CHAR, TITLE, SIGN, INT, FRAC, SCALE, FINISH
    } state_t;

    // Headroom so acc*10+9 never wraps before it is compared with the limit.
    localparam int WIDE = ACC_BITS + 4;
    localparam logic [2:0] FD = 3'(FRAC_DIGITS);
    typedef logic [WIDE-1:0] wide_t;

    // Returns {overflow, clamped value}.
    function automatic logic [ACC_BITS:0] clamp(input wide_t value, input wide_t lim);
        return (value > lim) ? {1'b1, ACC_BITS'(lim)} : {1'b0, ACC_BITS'(value)};
    endfunction

    state_t              state, state_next;
    state_t              phase, phase_next;      // phase state to run once a char is in
    logic [ACC_BITS-1:0] acc, acc_next;          // unsigned magnitude
    logic [7:0]          ch, ch_next;
    logic                negative, negative_next;
    logic                seen_digit, seen_digit_next;
    logic                bad, bad_next;
    logic                eof, eof_next;          // source ran dry instead of delivering ch
    logic [2:0]          frac_cnt, frac_cnt_next;
    logic                done_next, success_next, too_big_next, has_frac_next;
    logic [NUM_BITS-1:0] num_next;
`ifdef ARG_SUBPARSER_ROUND_EN
    logic                round_up, round_up_next;
`endif

    logic                is_digit, is_term;
    wide_t               limit, digit, acc_x10;
    logic [ACC_BITS:0]   step;
    logic [ACC_BITS-1:0] signed_acc;

    assign is_digit   = !eof && (ch >= 8'h30) && (ch <= 8'h39);
    assign is_term    = eof || (ch == 8'h20) || (ch == 8'h0d) || (ch == 8'h0a);
    assign digit      = wide_t'(ch[3:0]);
    assign acc_x10    = (wide_t'(acc) << 3) + (wide_t'(acc) << 1);
    // Negative numbers reach one further than positive ones.
    assign limit      = negative ? (wide_t'(1) << (NUM_BITS - 1))
                                 : ((wide_t'(1) << (NUM_BITS - 1)) - wide_t'(1));
    assign signed_acc = negative ? (~acc + ACC_BITS'(1)) : acc;
    assign rdy        = (state == IDLE);

    always_comb begin
        // NOTE: every next value defaults to its current value first, so no
        // branch of the case below can leave a signal unassigned and infer a latch.
        state_next      = state;
        phase_next      = phase;
        acc_next        = acc;
        ch_next         = ch;
        negative_next   = negative;
        seen_digit_next = seen_digit;
        bad_next        = bad;
        eof_next        = eof;
        frac_cnt_next   = frac_cnt;
        done_next       = 1'b0;
        success_next    = success;
        too_big_next    = arg_too_big;
        has_frac_next   = has_frac;
        num_next        = num;
        rd_trigger      = 1'b0;
        step            = '0;
`ifdef ARG_SUBPARSER_ROUND_EN
        round_up_next   = round_up;
`endif

        case (state)
            IDLE: begin
                if (trigger) begin
                    acc_next        = '0;
                    negative_next   = 1'b0;
                    seen_digit_next = 1'b0;
                    bad_next        = 1'b0;
                    eof_next        = 1'b0;
                    frac_cnt_next   = '0;
                    success_next    = 1'b0;
                    too_big_next    = 1'b0;
                    has_frac_next   = 1'b0;
`ifdef ARG_SUBPARSER_ROUND_EN
                    round_up_next   = 1'b0;
`endif
                    phase_next      = TITLE;
                    state_next      = FETCH;
                end
            end

            FETCH: begin
                if (is_empty) begin
                    eof_next   = 1'b1;
                    state_next = phase;
                end else if (rd_rdy) begin
                    // Gated so the request only fires on a cycle the FSM really advances.
                    rd_trigger = clk_en;
                    state_next = WAIT_CHAR;
                end
            end

            WAIT_CHAR: begin
                if (rd_done) begin
                    ch_next    = char_in;
                    eof_next   = 1'b0;
                    state_next = phase;
                end
            end

            TITLE: begin
                if (!eof && ch == arg_title) begin
                    phase_next = SIGN;
                    state_next = FETCH;
                end else begin
                    bad_next   = 1'b1;
                    state_next = FINISH;
                end
            end

            SIGN: begin
                if (!eof && (ch == 8'h2d || ch == 8'h2b)) begin
                    negative_next = (ch == 8'h2d);
                    phase_next    = INT;
                    state_next    = FETCH;
                end else if (is_digit || (!eof && ch == 8'h2e)) begin
                    // No sign: let INT consume this same character.
                    phase_next = INT;
                    state_next = INT;
                end else begin
                    bad_next   = 1'b1;
                    state_next = FINISH;
                end
            end

            INT: begin
                if (is_digit) begin
                    step            = clamp(acc_x10 + digit, limit);
                    acc_next        = step[ACC_BITS-1:0];
                    too_big_next    = arg_too_big | step[ACC_BITS];
                    seen_digit_next = 1'b1;
                    state_next      = FETCH;
                end else if (!eof && ch == 8'h2e) begin
                    has_frac_next = 1'b1;
                    phase_next    = FRAC;
                    state_next    = FETCH;
                end else if (is_term) begin
                    state_next = SCALE;
                end else begin
                    bad_next   = 1'b1;
                    state_next = FINISH;
                end
            end

            FRAC: begin
                if (is_digit) begin
                    seen_digit_next = 1'b1;
                    if (frac_cnt < FD) begin
                        step          = clamp(acc_x10 + digit, limit);
                        acc_next      = step[ACC_BITS-1:0];
                        too_big_next  = arg_too_big | step[ACC_BITS];
                        frac_cnt_next = frac_cnt + 3'd1;
                    end
`ifdef ARG_SUBPARSER_ROUND_EN
                    else if (frac_cnt == FD) begin
                        // Only the first discarded digit decides rounding.
                        round_up_next = (ch >= 8'h35);
                        frac_cnt_next = FD + 3'd1;
                    end
`endif
                    state_next = FETCH;
                end else if (is_term) begin
                    state_next = SCALE;
                end else begin
                    bad_next   = 1'b1;
                    state_next = FINISH;
                end
            end

            SCALE: begin
                if (frac_cnt < FD) begin
                    step          = clamp(acc_x10, limit);
                    acc_next      = step[ACC_BITS-1:0];
                    too_big_next  = arg_too_big | step[ACC_BITS];
                    frac_cnt_next = frac_cnt + 3'd1;
                end else begin
`ifdef ARG_SUBPARSER_ROUND_EN
                    // Rounding only happens with all fraction digits present, so no scaling conflict.
                    step          = clamp(wide_t'(acc) + wide_t'(round_up), limit);
                    acc_next      = step[ACC_BITS-1:0];
                    too_big_next  = arg_too_big | step[ACC_BITS];
                    round_up_next = 1'b0;
`endif
                    state_next = FINISH;
                end
            end

            FINISH: begin
                num_next     = NUM_BITS'(signed_acc);
                success_next = seen_digit & ~bad;
                done_next    = 1'b1;
                state_next   = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            phase       <= TITLE;
            acc         <= '0;
            ch          <= '0;
            negative    <= 1'b0;
            seen_digit  <= 1'b0;
            bad         <= 1'b0;
            eof         <= 1'b0;
            frac_cnt    <= '0;
            done        <= 1'b0;
            success     <= 1'b0;
            arg_too_big <= 1'b0;
            has_frac    <= 1'b0;
            num         <= '0;
`ifdef ARG_SUBPARSER_ROUND_EN
            round_up    <= 1'b0;
`endif
        end else if (clk_en) begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            state       <= state_next;
            phase       <= phase_next;
            acc         <= acc_next;
            ch          <= ch_next;
            negative    <= negative_next;
            seen_digit  <= seen_digit_next;
            bad         <= bad_next;
            eof         <= eof_next;
            frac_cnt    <= frac_cnt_next;
            done        <= done_next;
            success     <= success_next;
            arg_too_big <= too_big_next;
            has_frac    <= has_frac_next;
            num         <= num_next;
`ifdef ARG_SUBPARSER_ROUND_EN
            round_up    <= round_up_next;
`endif
        end
    end

endmodule

// File: tb/tb_fixed_arg_subparser.sv
// -----------------------------------------------------------------------------
// tb_fixed_arg_subparser
//
// Drives fixed_arg_subparser (NUM_BITS=16, FRAC_DIGITS=2, title 'X') from a
// character queue through a randomly paced source handshake with a randomly
// toggling clk_en. Results are compared with constants for the directed
// vectors and with a string-level reference model for random arguments.
// -----------------------------------------------------------------------------
module tb_fixed_arg_subparser;

    localparam int NB   = 16;
    localparam int FRAC = 2;
    localparam logic [7:0] TITLE = 8'h58;  // 'X'
`ifdef ARG_SUBPARSER_ROUND_EN
    localparam longint ROUND_CASE_NUM = 124;
`else
    localparam longint ROUND_CASE_NUM = 123;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en, trigger;
    logic [7:0]    arg_title, char_in;
    logic          rd_rdy, rd_done, is_empty;
    logic          rd_trigger, rdy, done, success, arg_too_big, has_frac;
    logic [NB-1:0] num;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] src_q[$];

    typedef struct {
        bit     ok;
        bit     big;
        bit     frac;
        longint num;
        int     reads;
    } exp_t;

    fixed_arg_subparser #(.NUM_BITS(NB), .FRAC_DIGITS(FRAC)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .trigger    (trigger),
        .arg_title  (arg_title),
        .char_in    (char_in),
        .rd_rdy     (rd_rdy),
        .rd_done    (rd_done),
        .is_empty   (is_empty),
        .rd_trigger (rd_trigger),
        .rdy        (rdy),
        .done       (done),
        .success    (success),
        .arg_too_big(arg_too_big),
        .has_frac   (has_frac),
        .num        (num)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_dig(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    function automatic bit is_trm(input logic [7:0] c);
        return c == 8'h20 || c == 8'h0d || c == 8'h0a;
    endfunction

    function automatic void load_str(input string s);
        src_q.delete();
        for (int i = 0; i < s.len(); i++) src_q.push_back(s[i]);
    endfunction

    // Reference: reads the whole argument as text, then applies the value rules.
    function automatic exp_t model();
        exp_t   e;
        int     n, p, ndig;
        bit     neg, infrac;
        longint ival, mag, lim;
        int     fd[$];
        logic [7:0] c;
        e = '{ok: 1'b0, big: 1'b0, frac: 1'b0, num: 0, reads: 0};
        n = src_q.size();
        if (n == 0) return e;
        if (src_q[0] != TITLE) begin
            e.reads = 1;
            return e;
        end
        p = 1; neg = 0; ival = 0; infrac = 0; ndig = 0;
        if (p < n && (src_q[p] == 8'h2d || src_q[p] == 8'h2b)) begin
            neg = (src_q[p] == 8'h2d);
            p++;
        end
        e.reads = n;
        while (p < n) begin
            c = src_q[p];
            if (is_dig(c)) begin
                ndig++;
                if (infrac) fd.push_back(int'(c) - 48);
                else ival = ival * 10 + longint'(int'(c) - 48);
            end else if (c == 8'h2e && !infrac) begin
                infrac = 1;
                e.frac = 1;
            end else if (is_trm(c)) begin
                e.reads = p + 1;
                break;
            end else begin
                e.reads = p + 1;
                return e;
            end
            p++;
        end
        if (ndig == 0) return e;
        mag = ival;
        for (int k = 0; k < FRAC; k++) mag = mag * 10 + ((k < fd.size()) ? longint'(fd[k]) : 0);
`ifdef ARG_SUBPARSER_ROUND_EN
        if (fd.size() > FRAC && fd[FRAC] >= 5) mag++;
`endif
        lim = neg ? 64'sd32768 : 64'sd32767;
        e.big = (mag > lim);
        if (e.big) mag = lim;
        e.num = neg ? -mag : mag;
        e.ok  = 1;
        return e;
    endfunction

    // Runs one parse of src_q; returns whether done arrived and how many chars were requested.
    task automatic run_parse(output bit got_done, output int reads);
        int idx = 0;
        bit pending = 0;
        int delay = 0;
        logic [7:0] cur = 8'h00;
        got_done = 0;
        @(negedge clk);
        clk_en = 1; trigger = 1; rd_done = 0; rd_rdy = 0; is_empty = 0;
        @(negedge clk);
        trigger = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (done) begin
                got_done = 1;
                break;
            end
            if (rd_done && clk_en) rd_done = 0;  // delivered on the edge just passed
            clk_en = ($urandom_range(0, 3) != 0);
            rd_rdy = ($urandom_range(0, 4) != 0);
            if (pending && !rd_done) begin
                if (delay == 0) begin
                    rd_done = 1;
                    char_in = cur;
                    pending = 0;
                end else begin
                    delay--;
                end
            end
            is_empty = (idx >= src_q.size()) && !pending && !rd_done;
            #1;
            if (rd_trigger && idx < src_q.size()) begin
                cur     = src_q[idx];
                idx++;
                pending = 1;
                delay   = $urandom_range(0, 2);
            end
            @(negedge clk);
        end
        reads = idx;
        rd_done = 0; rd_rdy = 0; is_empty = 0; clk_en = 1;
    endtask

    task automatic spec_case(input string tag, input string s, input bit ok, input bit big,
                             input bit frac, input longint n, input int rd);
        bit got;
        int reads;
        load_str(s);
        run_parse(got, reads);
        check({tag, "_done"}, got, 1);
        check({tag, "_reads"}, reads, rd);
        check({tag, "_success"}, success, ok);
        if (ok) begin
            check({tag, "_has_frac"}, has_frac, frac);
            check({tag, "_too_big"}, arg_too_big, big);
            check({tag, "_num"}, $signed(num), n);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic model_case(input string tag);
        exp_t e;
        bit   got;
        int   reads;
        e = model();
        run_parse(got, reads);
        check({tag, "_done"}, got, 1);
        check({tag, "_reads"}, reads, e.reads);
        check({tag, "_success"}, success, e.ok);
        if (e.ok) begin
            check({tag, "_has_frac"}, has_frac, e.frac);
            check({tag, "_too_big"}, arg_too_big, e.big);
            check({tag, "_num"}, $signed(num), e.num);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic build_random();
        logic [7:0] junk[4] = '{8'h61, 8'h2e, 8'h2d, 8'h5a};
        int nint, nfrac, term;
        src_q.delete();
        src_q.push_back(($urandom_range(0, 9) == 0) ? 8'h59 : TITLE);
        case ($urandom_range(0, 2))
            1: src_q.push_back(8'h2d);
            2: src_q.push_back(8'h2b);
            default: ;
        endcase
        nint = ($urandom_range(0, 5) == 0) ? 6 : $urandom_range(0, 4);
        for (int i = 0; i < nint; i++) src_q.push_back(8'(8'h30 + $urandom_range(0, 9)));
        if ($urandom_range(0, 1) == 1) begin
            src_q.push_back(8'h2e);
            nfrac = $urandom_range(0, 4);
            for (int i = 0; i < nfrac; i++) src_q.push_back(8'(8'h30 + $urandom_range(0, 9)));
        end
        if ($urandom_range(0, 7) == 0)
            src_q.insert($urandom_range(1, src_q.size()), junk[$urandom_range(0, 3)]);
        term = $urandom_range(0, 3);
        if (term == 1) src_q.push_back(8'h20);
        else if (term == 2) src_q.push_back(8'h0d);
        else if (term == 3) src_q.push_back(8'h0a);
    endtask

    initial begin
        bit any_rt, any_done, saw_req;
        reset = 0; clk_en = 0; trigger = 0; arg_title = TITLE; char_in = 8'h00;
        rd_rdy = 0; rd_done = 0; is_empty = 0;
        #3;
        check("rst_rdy", rdy, 1);
        check("rst_done", done, 0);
        check("rst_rd_trigger", rd_trigger, 0);
        check("rst_num", $signed(num), 0);
        #9 reset = 1;

        spec_case("frac_12_5", "X12.5 ", 1, 0, 1, 1250, 6);
        spec_case("neg_3_lf", "X-3\n", 1, 0, 0, -300, 4);
        spec_case("pos_sat", "X400 ", 1, 1, 0, 32767, 5);
        spec_case("neg_sat", "X-400 ", 1, 1, 0, -32768, 6);
        spec_case("pos_max", "X327.67\r", 1, 0, 1, 32767, 8);
        spec_case("neg_max", "X-327.68 ", 1, 0, 1, -32768, 9);
        spec_case("pos_max_p1", "X327.68 ", 1, 1, 1, 32767, 8);
        spec_case("frac_only", "X.5", 1, 0, 1, 50, 3);
        spec_case("bad_title", "Y5 ", 0, 0, 0, 0, 1);
        spec_case("sign_only", "X- ", 0, 0, 0, 0, 3);
        spec_case("empty_src", "", 0, 0, 0, 0, 0);
        spec_case("round", "X1.236 ", 1, 0, 1, ROUND_CASE_NUM, 7);

        // Reset while waiting for a character, with clk_en toggling.
        load_str("X7 ");
        @(negedge clk);
        clk_en = 1; trigger = 1; rd_rdy = 1; is_empty = 0;
        @(negedge clk);
        trigger = 0;
        saw_req = 0;
        for (int i = 0; i < 10 && !saw_req; i++) begin
            #1;
            if (rd_trigger) saw_req = 1;
            else @(negedge clk);
        end
        check("rst_fetch_req", saw_req, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clk_en = ~clk_en;
        end
        @(negedge clk);
        #2 reset = 0;
        #1;
        check("abort_rdy", rdy, 1);
        check("abort_rd_trigger", rd_trigger, 0);
        check("abort_done", done, 0);
        check("abort_success", success, 0);
        check("abort_too_big", arg_too_big, 0);
        check("abort_has_frac", has_frac, 0);
        check("abort_num", $signed(num), 0);
        any_rt = 0; any_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clk_en = ~clk_en;
            #1;
            any_rt |= rd_trigger;
            any_done |= done;
        end
        #1 reset = 1;
        clk_en = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            any_rt |= rd_trigger;
            any_done |= done;
        end
        check("abort_no_request", any_rt, 0);
        check("abort_no_done", any_done, 0);
        spec_case("after_reset", "X7 ", 1, 0, 0, 700, 3);

        for (int r = 0; r < 40; r++) begin
            build_random();
            model_case($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fixed_arg_subparser.md
FIXED_ARG_SUBPARSER -- requirements
Module: fixed_arg_subparser

Interface
REQ-001 SHALL have parameter NUM_BITS, default 16: width of the signed two's-complement result.
REQ-002 SHALL have parameter FRAC_DIGITS, default 2, range 0..4: decimal fraction digits kept; num = value*10^FRAC_DIGITS.
REQ-003 SHALL have parameter ACC_BITS, default NUM_BITS+4: internal magnitude accumulator width.
REQ-004 SHALL have port clk  input  1  the only clock; all state updates on posedge clk.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (reset==0 resets).
REQ-006 SHALL have ports clk_en  input  1  (advance enable; no state change when 0), trigger  input  1  (start one parse), arg_title  input  8  (expected ASCII title letter).
REQ-007 SHALL have ports char_in  input  8  (source char, valid when rd_done=1), rd_rdy  input  1  (source ready), rd_done  input  1  (char delivered), is_empty  input  1  (source exhausted).
REQ-008 SHALL have ports rd_trigger  output  1  (one-cycle char request), rdy  output  1  (idle, accepts trigger), done  output  1  (one-cycle completion pulse).
REQ-009 SHALL have ports success  output  1, arg_too_big  output  1, has_frac  output  1 (a '.' was parsed), num  output  NUM_BITS (signed fixed-point result).

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, WAIT_CHAR, TITLE, SIGN, INT, FRAC, SCALE, FINISH.
REQ-011 SHALL in IDLE hold rdy=1; trigger=1 with clk_en=1 clears success/arg_too_big/has_frac/accumulator, then -> FETCH.
REQ-012 SHALL in FETCH wait for rd_rdy=1, pulse rd_trigger for exactly one cycle, -> WAIT_CHAR; is_empty=1 in FETCH ends the argument as a terminator.
REQ-013 SHALL in WAIT_CHAR register char_in on the cycle rd_done=1, then dispatch to the phase state.
REQ-014 SHALL in TITLE require char == arg_title; otherwise -> FINISH with success=0.
REQ-015 SHALL in SIGN accept one optional '-' (sets negative) or '+', then digits; a digit falls through to INT.
REQ-016 SHALL in INT accumulate acc = acc*10 + digit; '.' -> FRAC with has_frac=1; space, CR, LF or empty source -> SCALE.
REQ-017 SHALL in FRAC accumulate only the first FRAC_DIGITS digits and count them; later digits are consumed and discarded (see REQ-028).
REQ-018 SHALL in SCALE multiply acc by 10 once per cycle per missing fraction digit (FRAC_DIGITS - counted), then -> FINISH.
REQ-019 SHALL require at least one digit (integer or fraction) for success=1; any other character, or a terminator before a digit, gives success=0.
REQ-020 SHALL set arg_too_big=1 when magnitude exceeds 2^(NUM_BITS-1)-1 (positive) or 2^(NUM_BITS-1) (negative) at any step; accumulator then saturates and parsing continues until a terminator.
REQ-021 SHALL on overflow drive num to the saturated limit (0x7FFF / 0x8000 at NUM_BITS=16); success still 1 if syntax valid.
REQ-022 SHALL in FINISH drive num = negative ? -acc : acc, pulse done for one cycle, -> IDLE; outputs hold until next trigger.
REQ-023 SHALL ignore trigger outside IDLE; terminator character is consumed.
REQ-024 SHALL freeze all state and outputs except combinational decode while clk_en=0, including mid-handshake.

Reset
REQ-025 SHALL on reset==0 immediately force IDLE, rdy=1, rd_trigger=0, done=0, success=0, arg_too_big=0, has_frac=0, num=0, accumulator/counters=0.
REQ-026 SHALL abort any parse in progress on reset without emitting done; no char request issued until the next trigger after release.

Configuration
REQ-027 SHALL compile rounding logic only when macro ARG_SUBPARSER_ROUND_EN is defined.
REQ-028 SHALL with ARG_SUBPARSER_ROUND_EN add 1 to magnitude (with saturation check) when the first discarded fraction digit is >=5; without it, extra fraction digits are truncated.

Verification (NUM_BITS=16, FRAC_DIGITS=2, arg_title='X')
REQ-029 SHALL test "X12.5 " -> done pulse, success=1, has_frac=1, num=1250, arg_too_big=0.
REQ-030 SHALL test "X-3\n" -> success=1, has_frac=0, num=-300 (0xFED4).
REQ-031 SHALL test "X400 " -> arg_too_big=1, success=1, num=32767; "X-400 " -> num=-32768.
REQ-032 SHALL test "Y5 " -> done after one char read, success=0; "X- " -> success=0.
REQ-033 SHALL test "X1.236 " -> num=124 with ARG_SUBPARSER_ROUND_EN, num=123 without.
REQ-034 SHALL test reset asserted during WAIT_CHAR with clk_en toggling -> immediate IDLE, no done, all outputs 0, next "X7 " yields num=700.
